serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4: number of 4-bit slices per operand. Legal range 2..8. Operand width W = 4*NIBBLES.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start_valid, input, 1 bit: requester presents an operation.
REQ-005 SHALL have port start_ready, output, 1 bit: controller can accept an operation.
REQ-006 SHALL have port op_a, input, W bits: operand A.
REQ-007 SHALL have port op_b, input, W bits: operand B.
REQ-008 SHALL have port cin, input, 1 bit: carry-in to the least significant nibble.
REQ-009 SHALL have port res_valid, output, 1 bit: sum and cout are valid.
REQ-010 SHALL have port res_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port sum, output, W bits: result.
REQ-012 SHALL have port cout, output, 1 bit: carry out of the most significant nibble.

Function
REQ-013 SHALL compute {cout,sum} = op_a + op_b + cin by time-multiplexing exactly one instance of the team's 4-bit ripple adder (4-bit a, 4-bit b, c0 in; 4-bit f, c4 out), one nibble per cycle, LSB nibble first.
REQ-014 SHALL implement a three-state FSM:
- IDLE to BUSY on start handshake.
- BUSY to DONE after NIBBLES BUSY cycles.
- DONE to IDLE on result handshake.
REQ-015 SHALL drive start_ready = 1 only in IDLE, combinationally from state.
REQ-016 SHALL treat a start handshake as start_valid && start_ready at a rising edge. On the handshake it SHALL latch op_a, op_b and cin, and set nibble index = 0.
REQ-017 In BUSY, each cycle SHALL:
- feed nibble[idx] of the latched operands and the carry register to the adder;
- write f into sum[4*idx+3:4*idx];
- load c4 into the carry register;
- increment idx.
REQ-018 SHALL leave BUSY on the edge where idx == NIBBLES-1, loading cout from the final c4 and setting res_valid = 1.
REQ-019 Latency: start handshake at edge k SHALL give res_valid = 1 after edge k+NIBBLES. The controller accepts at most one operation per NIBBLES+2 cycles.
REQ-020 SHALL hold res_valid, sum and cout stable in DONE while res_ready = 0, for any number of cycles.
REQ-021 On a result handshake (res_valid && res_ready) SHALL return to IDLE and clear res_valid. sum and cout retain their values until the next BUSY write.
REQ-022 SHALL ignore start_valid and operand changes while in BUSY or DONE. No input sampling occurs outside the start handshake.
REQ-023 SHALL ignore res_ready outside DONE.
REQ-024 Carry wraps: the final carry SHALL appear only on cout, never folded back into sum. W-bit overflow is reported solely by cout.

Reset
REQ-025 Asserting rst SHALL, asynchronously and in any state including mid-BUSY:
- force state = IDLE;
- set res_valid = 0, sum = 0, cout = 0;
- clear the carry register, idx and the latched operands.
REQ-026 SHALL make start_ready = 1 while and after rst, because it follows from state IDLE. An operation in flight at reset SHALL be discarded with no result produced.

Configuration
REQ-027 SHALL recognise macro SERIAL_ADD_SUB_EN.
- When defined: add input port sub (1 bit), latched on start handshake. With sub = 1, each op_b nibble is bitwise inverted before the adder, the initial carry is forced to 1 (cin ignored), and the result is op_a - op_b with cout = 1 meaning no borrow. With sub = 0, behaviour is per REQ-013.
- When undefined: no sub port and no inversion logic; behaviour is REQ-013 only.

Verification
REQ-028 SHALL cover: NIBBLES=4, op_a=0x00FF, op_b=0x0001, cin=0, res_ready=1 -> res_valid rises 4 edges after accept, sum=0x0100, cout=0.
REQ-029 SHALL cover: op_a=0xFFFF, op_b=0x0000, cin=1 -> sum=0x0000, cout=1.
REQ-030 SHALL cover: res_ready held 0 for 5 cycles after res_valid -> sum/cout/res_valid unchanged; start_ready stays 0; a start_valid pulse with new operands meanwhile is not accepted.
REQ-031 SHALL cover: rst pulsed 2 cycles after accepting 0x1234+0x1111 -> res_valid=0, sum=0, start_ready=1 immediately. The next operation 0x0001+0x0002 yields 0x0003, cout=0.
REQ-032 SHALL cover: back-to-back operations with start_valid held high -> second accept occurs the edge after the first result handshake; both results correct.
REQ-033 With SERIAL_ADD_SUB_EN defined, SHALL cover: sub=1, op_a=0x1000, op_b=0x0001 -> sum=0x0FFF, cout=1. Also sub=1, op_a=0x0000, op_b=0x0001 -> sum=0xFFFF, cout=0.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl -- nibble-serial adder controller.
//
// Computes {cout, sum} = op_a + op_b + cin by reusing one 4-bit ripple adder.
// The adder handles one nibble per clock, least significant nibble first.
// Operands and carry-in are captured on the start handshake. The result is
// held until the consumer accepts it.
//
// Optional build macro SERIAL_ADD_SUB_EN adds a 'sub' input. With sub = 1 the
// block computes op_a - op_b: the op_b nibbles are inverted, the initial carry
// is forced to 1, and cout = 1 means no borrow occurred.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   start_valid  requester presents an operation
//   start_ready  high only in IDLE
//   op_a, op_b   W-bit operands (W = 4*NIBBLES)
//   cin          carry-in to the least significant nibble
//   sub          (SERIAL_ADD_SUB_EN only) subtract select
//   res_valid    sum/cout are valid
//   res_ready    consumer accepts the result
//   sum          W-bit result
//   cout         carry out of the most significant nibble
//
// State table:
//   IDLE | waiting for a start handshake, start_ready = 1
//   BUSY | one nibble per cycle through the shared adder
//   DONE | result presented, waiting for the result handshake

// 4-bit ripple-carry adder: f = a + b + c0, c4 = carry out.
module ripple_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] f,
  output logic       c4
);
  logic [4:0] c;

  always_comb begin
    c    = '0;
    f    = '0;
    c[0] = c0;
    for (int i = 0; i < 4; i++) begin
      f[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    c4 = c[4];
  end
endmodule

module serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic                   sub,
`endif
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, b_q;
  logic [W-1:0]     sum_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic             cout_q;
  logic             res_valid_q;

  logic             start_fire;
  logic             res_fire;
  logic             busy_last;

  logic [3:0]       add_a, add_b, add_f;
  logic             add_c4;
  logic [3:0]       b_nib;

`ifdef SERIAL_ADD_SUB_EN
  logic             sub_q;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake strobes.
  always_comb begin
    state_d     = state_q;
    start_ready = 1'b0;
    start_fire  = 1'b0;
    res_fire    = 1'b0;
    busy_last   = 1'b0;
    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          start_fire = 1'b1;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (idx_q == LAST_IDX) begin
          busy_last = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        // res_valid is always high in DONE, so res_ready alone completes it.
        if (res_ready) begin
          res_fire = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Select the current nibble of the latched operands.
  always_comb begin
    add_a = a_q[{idx_q, 2'b00} +: 4];
    b_nib = b_q[{idx_q, 2'b00} +: 4];
`ifdef SERIAL_ADD_SUB_EN
    add_b = sub_q ? ~b_nib : b_nib;
`else
    add_b = b_nib;
`endif
  end

  ripple_add4 u_add (
    .a  (add_a),
    .b  (add_b),
    .c0 (carry_q),
    .f  (add_f),
    .c4 (add_c4)
  );

  // Datapath. sum/cout only change in BUSY, so they hold through DONE and IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      cout_q      <= 1'b0;
      res_valid_q <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      if (start_fire) begin
        a_q   <= op_a;
        b_q   <= op_b;
        idx_q <= '0;
`ifdef SERIAL_ADD_SUB_EN
        sub_q   <= sub;
        // Two's-complement subtract: invert b and add one through the carry.
        carry_q <= sub ? 1'b1 : cin;
`else
        carry_q <= cin;
`endif
      end
      if (state_q == BUSY) begin
        sum_q[{idx_q, 2'b00} +: 4] <= add_f;
        carry_q                    <= add_c4;
        idx_q                      <= idx_q + IDX_W'(1);
        if (busy_last) begin
          cout_q      <= add_c4;
          res_valid_q <= 1'b1;
        end
      end
      if (res_fire) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign res_valid = res_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;
  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a, op_b;
  logic         cin;
  logic         sub;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] sum;
  logic         cout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .cin         (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub         (sub),
`endif
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on W+1 bits.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic ci, input logic s);
    if (s) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b} + (W+1)'(ci);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until res_valid rises; bounded.
  task automatic wait_result(input bit rand_ready, output int lat);
    lat = 0;
    while (!res_valid && lat < 20) begin
      if (rand_ready) res_ready = 1'($urandom);
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input int hold, input bit poke);
    int w;
    int lat;
    logic [W:0] exp;
    exp = model(a, b, ci, sub);
    w = 0;
    while (!start_ready && w < 20) begin
      tick();
      w++;
    end
    check("start_ready_idle", 32'(start_ready), 32'd1);
    start_valid = 1'b1;
    op_a = a;
    op_b = b;
    cin  = ci;
    tick();
    start_valid = 1'b0;
    op_a = W'($urandom);
    op_b = W'($urandom);
    cin  = 1'($urandom);
    check("busy_start_ready", 32'(start_ready), 32'd0);
    wait_result(1'b1, lat);
    check("latency", 32'(lat), 32'(NIBBLES));
    check("sum", 32'(sum), 32'(exp[W-1:0]));
    check("cout", 32'(cout), 32'(exp[W]));
    res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        start_valid = 1'b1;
        op_a = W'($urandom);
        op_b = W'($urandom);
      end
      tick();
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_sum", 32'(sum), 32'(exp[W-1:0]));
      check("hold_cout", 32'(cout), 32'(exp[W]));
      check("hold_start_ready", 32'(start_ready), 32'd0);
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("release_valid", 32'(res_valid), 32'd0);
    check("release_start_ready", 32'(start_ready), 32'd1);
    check("retain_sum", 32'(sum), 32'(exp[W-1:0]));
    check("retain_cout", 32'(cout), 32'(exp[W]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [W:0] e1, e2;

    rst = 1'b1;
    start_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    cin = 1'b0;
    sub = 1'b0;
    res_ready = 1'b0;
    #2;
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Directed cases.
    run_op(16'h00FF, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 2, 1'b0);
    // Result held under back-pressure; a start pulse meanwhile must be ignored.
    run_op(16'hABCD, 16'h1357, 1'b0, 5, 1'b1);

    // Reset in mid-BUSY discards the operation.
    start_valid = 1'b1;
    op_a = 16'h1234;
    op_b = 16'h1111;
    cin = 1'b0;
    tick();
    start_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst_res_valid", 32'(res_valid), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    check("midrst_start_ready", 32'(start_ready), 32'd1);
    tick();
    rst = 1'b0;
    check("postrst_start_ready", 32'(start_ready), 32'd1);
    check("postrst_res_valid", 32'(res_valid), 32'd0);
    run_op(16'h0001, 16'h0002, 1'b0, 0, 1'b0);

    // Back-to-back with start_valid held high.
    e1 = model(16'h8000, 16'h8000, 1'b0, 1'b0);
    e2 = model(16'h0F0F, 16'hF0F0, 1'b1, 1'b0);
    res_ready = 1'b1;
    start_valid = 1'b1;
    op_a = 16'h8000;
    op_b = 16'h8000;
    cin = 1'b0;
    check("b2b_ready1", 32'(start_ready), 32'd1);
    tick();
    op_a = 16'h0F0F;
    op_b = 16'hF0F0;
    cin = 1'b1;
    wait_result(1'b0, lat);
    check("b2b_lat1", 32'(lat), 32'(NIBBLES));
    check("b2b_sum1", 32'(sum), 32'(e1[W-1:0]));
    check("b2b_cout1", 32'(cout), 32'(e1[W]));
    tick();
    check("b2b_handshake", 32'(res_valid), 32'd0);
    check("b2b_idle", 32'(start_ready), 32'd1);
    tick();
    check("b2b_second_accept", 32'(start_ready), 32'd0);
    start_valid = 1'b0;
    op_a = W'($urandom);
    op_b = W'($urandom);
    wait_result(1'b0, lat);
    check("b2b_lat2", 32'(lat), 32'(NIBBLES));
    check("b2b_sum2", 32'(sum), 32'(e2[W-1:0]));
    check("b2b_cout2", 32'(cout), 32'(e2[W]));
    tick();
    check("b2b_done", 32'(res_valid), 32'd0);
    res_ready = 1'b0;

`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b1;
    run_op(16'h1000, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0, 1, 1'b0);
    sub = 1'b0;
`endif

    // Random operations with random back-pressure.
    for (int n = 0; n < 40; n++) begin
`ifdef SERIAL_ADD_SUB_EN
      sub = 1'($urandom);
`endif
      run_op(W'($urandom), W'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
